// File: rtl/hci_ecc_encoder_if.sv
// rtl/hci_ecc_encoder_if.sv - HCI core request/response interface with optional ecc sideband
interface hci_core_intf #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int UW = 1,
  parameter int EW = 1
) ();
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] be;
  logic [UW-1:0]   user;
  logic [EW-1:0]   ecc;
  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic            r_ready;
  logic [UW-1:0]   r_user;
  logic [EW-1:0]   r_ecc;
  logic            r_opc;

  modport initiator (
    output req, add, wen, data, be, user, ecc, r_ready,
    input  gnt, r_data, r_valid, r_user, r_ecc, r_opc
  );
  modport target (
    input  req, add, wen, data, be, user, ecc, r_ready,
    output gnt, r_data, r_valid, r_user, r_ecc, r_opc
  );
endinterface

// File: rtl/hci_ecc_encoder.sv
// rtl/hci_ecc_encoder.sv - Hsiao SECDED encode of HCI requests, decode/correct of responses, error counters
// Optional 1-entry request slice enabled by HCI_ECC_ENCODER_REQ_SLICE_EN.
module hci_ecc_encoder #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int UW         = 1,
  parameter int CHUNK_SIZE = 32,
  parameter int CNT_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  hci_core_intf.target             tcdm_target,
  hci_core_intf.initiator          tcdm_initiator,
  output logic [DW/CHUNK_SIZE-1:0] r_single_err_o,
  output logic [DW/CHUNK_SIZE-1:0] r_multi_err_o,
  output logic [CNT_W-1:0]         corr_cnt_o,
  output logic [CNT_W-1:0]         uncorr_cnt_o
);
  localparam int N_CHUNK = DW / CHUNK_SIZE;
  localparam int PW      = $clog2(CHUNK_SIZE) + 2;
  localparam int MP      = 8;
  localparam int BW      = DW / 8;
  localparam int MW      = AW + 1 + BW;
  localparam int DEW     = N_CHUNK * PW;
  localparam int EW      = DEW + MP;
  localparam int CW1     = CNT_W + 1;

  // Column n is the n-th odd-weight (>=3) vector, ordered by weight then value; 16-bit stride, max 64 columns.
  function automatic logic [1023:0] hsiao_table(input int p, input int cols);
    logic [1023:0] t;
    int n;
    t = '0;
    n = 0;
    for (int w = 3; w <= p; w += 2)
      for (int c = 0; c < (1 << p); c++)
        if ($countones(c) == w && n < cols) begin
          t[n*16 +: 16] = c[15:0];
          n = n + 1;
        end
    return t;
  endfunction

  localparam logic [1023:0] DATA_H = hsiao_table(PW, CHUNK_SIZE);
  localparam logic [1023:0] META_H = hsiao_table(MP, MW);

  function automatic logic [PW-1:0] enc_data(input logic [CHUNK_SIZE-1:0] d);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK_SIZE; i++)
      if (d[i]) c = c ^ DATA_H[i*16 +: PW];
    return c;
  endfunction

  function automatic logic [MP-1:0] enc_meta(input logic [MW-1:0] m);
    logic [MP-1:0] c;
    c = '0;
    for (int i = 0; i < MW; i++)
      if (m[i]) c = c ^ META_H[i*16 +: MP];
    return c;
  endfunction

  logic [DEW-1:0] w_data_ecc;
  logic [EW-1:0]  w_ecc;

  for (genvar k = 0; k < N_CHUNK; k++) begin : g_enc
    assign w_data_ecc[k*PW +: PW] = enc_data(tcdm_target.data[k*CHUNK_SIZE +: CHUNK_SIZE]);
  end
  assign w_ecc = {enc_meta({tcdm_target.add, tcdm_target.wen, tcdm_target.be}), w_data_ecc};

`ifdef HCI_ECC_ENCODER_REQ_SLICE_EN
  logic            r_full;
  logic [AW-1:0]   r_add;
  logic            r_wen;
  logic [DW-1:0]   r_req_data;
  logic [BW-1:0]   r_be;
  logic [UW-1:0]   r_user;
  logic [EW-1:0]   r_ecc;
  logic            w_tgt_gnt;

  assign w_tgt_gnt = (~r_full | tcdm_initiator.gnt) & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full     <= 1'b0;
      r_add      <= '0;
      r_wen      <= 1'b0;
      r_req_data <= '0;
      r_be       <= '0;
      r_user     <= '0;
      r_ecc      <= '0;
    end else if (clear_i) begin
      r_full <= 1'b0;
    end else if (tcdm_target.req && w_tgt_gnt) begin
      r_full     <= 1'b1;
      r_add      <= tcdm_target.add;
      r_wen      <= tcdm_target.wen;
      r_req_data <= tcdm_target.data;
      r_be       <= tcdm_target.be;
      r_user     <= tcdm_target.user;
      r_ecc      <= w_ecc;
    end else if (tcdm_initiator.gnt) begin
      r_full <= 1'b0;
    end
  end

  assign tcdm_target.gnt     = w_tgt_gnt;
  assign tcdm_initiator.req  = r_full;
  assign tcdm_initiator.add  = r_add;
  assign tcdm_initiator.wen  = r_wen;
  assign tcdm_initiator.data = r_req_data;
  assign tcdm_initiator.be   = r_be;
  assign tcdm_initiator.user = r_user;
  assign tcdm_initiator.ecc  = r_ecc;
`else
  assign tcdm_target.gnt     = tcdm_initiator.gnt & ~rst_i;
  assign tcdm_initiator.req  = tcdm_target.req & ~rst_i;
  assign tcdm_initiator.add  = tcdm_target.add;
  assign tcdm_initiator.wen  = tcdm_target.wen;
  assign tcdm_initiator.data = tcdm_target.data;
  assign tcdm_initiator.be   = tcdm_target.be;
  assign tcdm_initiator.user = tcdm_target.user;
  assign tcdm_initiator.ecc  = w_ecc;
`endif

  logic               w_rsp_hs;
  logic [DW-1:0]      w_r_data;
  logic [N_CHUNK-1:0] w_single;
  logic [N_CHUNK-1:0] w_multi;

  assign w_rsp_hs = tcdm_initiator.r_valid & tcdm_target.r_ready & ~rst_i;

  for (genvar k = 0; k < N_CHUNK; k++) begin : g_dec
    logic [CHUNK_SIZE-1:0] w_d;
    logic [CHUNK_SIZE-1:0] w_fix;
    logic [PW-1:0]         w_syn;
    logic                  w_hit;
    logic                  w_sgl;

    assign w_d   = tcdm_initiator.r_data[k*CHUNK_SIZE +: CHUNK_SIZE];
    assign w_syn = enc_data(w_d) ^ tcdm_initiator.r_ecc[k*PW +: PW];

    always_comb begin
      w_fix = w_d;
      w_hit = 1'b0;
      for (int i = 0; i < CHUNK_SIZE; i++)
        if (w_syn == DATA_H[i*16 +: PW]) begin
          w_fix[i] = ~w_d[i];
          w_hit    = 1'b1;
        end
    end

    // A weight-1 syndrome is a flipped check bit; odd syndromes matching no column are treated as uncorrectable.
    assign w_sgl       = w_hit || ($countones(w_syn) == 1);
    assign w_single[k] = w_sgl;
    assign w_multi[k]  = (w_syn != '0) && !w_sgl;
    assign w_r_data[k*CHUNK_SIZE +: CHUNK_SIZE] = w_fix;
  end

  assign r_single_err_o         = w_single & {N_CHUNK{w_rsp_hs}};
  assign r_multi_err_o          = w_multi & {N_CHUNK{w_rsp_hs}};
  assign tcdm_target.r_data     = w_r_data;
  assign tcdm_target.r_valid    = tcdm_initiator.r_valid;
  assign tcdm_target.r_user     = tcdm_initiator.r_user;
  assign tcdm_target.r_opc      = tcdm_initiator.r_opc;
  assign tcdm_target.r_ecc      = '0;
  assign tcdm_initiator.r_ready = tcdm_target.r_ready;

  logic w_unused_bits;
  assign w_unused_bits = ^{tcdm_target.ecc, tcdm_initiator.r_ecc[EW-1:DEW]};

  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;
  logic [CNT_W:0]   w_corr_sum;
  logic [CNT_W:0]   w_uncorr_sum;

  assign w_corr_sum   = {1'b0, r_corr_cnt} + CW1'($countones(r_single_err_o));
  assign w_uncorr_sum = {1'b0, r_uncorr_cnt} + CW1'($countones(r_multi_err_o));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (clear_i) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      r_corr_cnt   <= w_corr_sum[CNT_W] ? '1 : w_corr_sum[CNT_W-1:0];
      r_uncorr_cnt <= w_uncorr_sum[CNT_W] ? '1 : w_uncorr_sum[CNT_W-1:0];
    end
  end

  assign corr_cnt_o   = r_corr_cnt;
  assign uncorr_cnt_o = r_uncorr_cnt;
endmodule

// File: tb/tb_hci_ecc_encoder.sv
// tb/tb_hci_ecc_encoder.sv - self-checking bench for hci_ecc_encoder with a Hsiao reference model
module tb_hci_ecc_encoder;
  localparam int DW = 32, AW = 32, UW = 1, CS = 32, CNT_W = 4;
  localparam int PW = 7, MP = 8, EW = PW + MP, MW = AW + 1 + DW/8;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, clear;
  logic [0:0] single_err, multi_err;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
  int n_tests = 0, n_fail = 0;
  int m_corr = 0, m_uncorr = 0;
  logic [7:0] dcol [CS];
  logic [7:0] mcol [MW];

  hci_core_intf #(.DW(DW), .AW(AW), .UW(UW), .EW(1))  tgt_if ();
  hci_core_intf #(.DW(DW), .AW(AW), .UW(UW), .EW(EW)) ini_if ();

  hci_ecc_encoder #(.DW(DW), .AW(AW), .UW(UW), .CHUNK_SIZE(CS), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .tcdm_target(tgt_if), .tcdm_initiator(ini_if),
    .r_single_err_o(single_err), .r_multi_err_o(multi_err),
    .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hsiao columns: odd-weight vectors of weight >= 3, listed by weight, then by value.
  task automatic build_model();
    int n;
    n = 0;
    for (int w = 3; w <= PW; w += 2)
      for (int v = 0; v < (1 << PW); v++)
        if ($countones(v) == w && n < CS) begin dcol[n] = v[7:0]; n++; end
    n = 0;
    for (int w = 3; w <= MP; w += 2)
      for (int v = 0; v < (1 << MP); v++)
        if ($countones(v) == w && n < MW) begin mcol[n] = v[7:0]; n++; end
  endtask

  function automatic logic [PW-1:0] m_data_ecc(input logic [CS-1:0] d);
    logic [PW-1:0] c;
    for (int j = 0; j < PW; j++) begin
      c[j] = 1'b0;
      for (int i = 0; i < CS; i++) c[j] = c[j] ^ (d[i] & dcol[i][j]);
    end
    return c;
  endfunction

  function automatic logic [MP-1:0] m_meta_ecc(input logic [MW-1:0] m);
    logic [MP-1:0] c;
    for (int j = 0; j < MP; j++) begin
      c[j] = 1'b0;
      for (int i = 0; i < MW; i++) c[j] = c[j] ^ (m[i] & mcol[i][j]);
    end
    return c;
  endfunction

  task automatic idle();
    tgt_if.req = 0; tgt_if.add = '0; tgt_if.wen = 0; tgt_if.data = '0; tgt_if.be = '0;
    tgt_if.user = '0; tgt_if.ecc = '0; tgt_if.r_ready = 0;
    ini_if.gnt = 0; ini_if.r_data = '0; ini_if.r_valid = 0; ini_if.r_user = '0;
    ini_if.r_ecc = '0; ini_if.r_opc = 0;
  endtask

  task automatic drive_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [3:0] b);
    tgt_if.req = 1; tgt_if.add = a; tgt_if.wen = w; tgt_if.data = d; tgt_if.be = b;
    tgt_if.user = 1'(d[0]);
  endtask

  // Codeword bits 0..31 are data, 32..38 the check bits; e0/e1 < 0 means no flip.
  task automatic drive_resp(input logic [31:0] d, input int e0, input int e1,
                            input logic v, input logic r, output logic [31:0] rx);
    logic [38:0] cw;
    cw = {m_data_ecc(d), d};
    if (e0 >= 0) cw[e0] = ~cw[e0];
    if (e1 >= 0) cw[e1] = ~cw[e1];
    rx = cw[31:0];
    ini_if.r_data = cw[31:0];
    ini_if.r_ecc = {8'($urandom), cw[38:32]};
    ini_if.r_valid = v; ini_if.r_opc = 1'($urandom); ini_if.r_user = 1'($urandom);
    tgt_if.r_ready = r;
  endtask

  task automatic clear_counters();
    clear = 1; tick(); clear = 0;
    m_corr = 0; m_uncorr = 0;
  endtask

  task automatic test_reset();
    drive_req(32'h40, 0, 32'hA5A5_0001, 4'hF);
    ini_if.gnt = 1; tgt_if.r_ready = 1; ini_if.r_valid = 1;
    ini_if.r_data = 32'h1; ini_if.r_ecc = '0;
    #2;
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", ini_if.req); end
    n_tests++; if (corr_cnt !== '0) begin n_fail++; $display("FAIL rst_corr: got %0d exp 0", corr_cnt); end
    n_tests++; if (uncorr_cnt !== '0) begin n_fail++; $display("FAIL rst_uncorr: got %0d exp 0", uncorr_cnt); end
    n_tests++; if (single_err !== 1'b0 || multi_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b/%b exp 0/0", single_err, multi_err); end
    repeat (2) @(posedge clk);
    #1; rst = 0; idle();
    #1;
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL post_rst_req: got %b exp 0", ini_if.req); end
  endtask

  task automatic test_write_encode();
    logic [EW-1:0] exp_ecc;
    drive_req(32'h100, 0, 32'hDEAD_BEEF, 4'hF);
    ini_if.gnt = 1;
    exp_ecc = {m_meta_ecc({32'h100, 1'b0, 4'hF}), m_data_ecc(32'hDEAD_BEEF)};
`ifdef HCI_ECC_ENCODER_REQ_SLICE_EN
    tick(); tgt_if.req = 0;
`else
    #1;
`endif
    n_tests++; if (ini_if.req !== 1'b1) begin n_fail++; $display("FAIL wr_req: got %b exp 1", ini_if.req); end
    n_tests++; if (ini_if.data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_data: got %h exp deadbeef", ini_if.data); end
    n_tests++; if (ini_if.ecc !== exp_ecc) begin n_fail++; $display("FAIL wr_ecc: got %h exp %h", ini_if.ecc, exp_ecc); end
    n_tests++; if (ini_if.add !== 32'h100 || ini_if.be !== 4'hF || ini_if.wen !== 1'b0)
      begin n_fail++; $display("FAIL wr_meta: got %h/%h/%b exp 100/f/0", ini_if.add, ini_if.be, ini_if.wen); end
    tick(); idle();
  endtask

  task automatic test_random_encode();
    logic [AW-1:0] a; logic [DW-1:0] d; logic [3:0] b; logic w; logic [EW-1:0] exp_ecc;
    ini_if.gnt = 1;
    for (int k = 0; k < 16; k++) begin
      a = $urandom; d = $urandom; b = 4'($urandom); w = 1'($urandom);
      drive_req(a, w, d, b);
      exp_ecc = {m_meta_ecc({a, w, b}), m_data_ecc(d)};
`ifdef HCI_ECC_ENCODER_REQ_SLICE_EN
      tick();
`else
      #1;
`endif
      n_tests++; if (ini_if.ecc !== exp_ecc) begin n_fail++; $display("FAIL rnd_ecc[%0d]: got %h exp %h", k, ini_if.ecc, exp_ecc); end
      n_tests++; if (ini_if.req !== 1'b1 || ini_if.data !== d || ini_if.add !== a || ini_if.be !== b || ini_if.wen !== w || ini_if.user !== 1'(d[0]))
        begin n_fail++; $display("FAIL rnd_pass[%0d]: got %h/%h/%h exp %h/%h/%h", k, ini_if.data, ini_if.add, ini_if.be, d, a, b); end
      n_tests++; if (tgt_if.gnt !== 1'b1) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b exp 1", k, tgt_if.gnt); end
`ifndef HCI_ECC_ENCODER_REQ_SLICE_EN
      tick();
`endif
    end
    tgt_if.req = 0;
    tick();
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: got %b exp 0", ini_if.req); end
    idle();
  endtask

  task automatic test_stall();
`ifdef HCI_ECC_ENCODER_REQ_SLICE_EN
    ini_if.gnt = 0;
    drive_req(32'hA0, 0, 32'h1111_AAAA, 4'h3);
    tick();
    drive_req(32'hB0, 1, 32'h2222_BBBB, 4'hC);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (ini_if.req !== 1'b1 || ini_if.data !== 32'h1111_AAAA || ini_if.add !== 32'hA0)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h exp 1/1111aaaa", k, ini_if.req, ini_if.data); end
      n_tests++; if (tgt_if.gnt !== 1'b0) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b exp 0", k, tgt_if.gnt); end
      tick();
    end
    ini_if.gnt = 1;
    #1;
    n_tests++; if (tgt_if.gnt !== 1'b1) begin n_fail++; $display("FAIL stall_release_gnt: got %b exp 1", tgt_if.gnt); end
    tick();
    tgt_if.req = 0;
    n_tests++; if (ini_if.req !== 1'b1 || ini_if.data !== 32'h2222_BBBB || ini_if.wen !== 1'b1)
      begin n_fail++; $display("FAIL stall_next: got %b/%h exp 1/2222bbbb", ini_if.req, ini_if.data); end
    tick();
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL stall_dup: got %b exp 0", ini_if.req); end
`else
    ini_if.gnt = 0;
    drive_req(32'hA0, 0, 32'h1111_AAAA, 4'h3);
    #1;
    n_tests++; if (tgt_if.gnt !== 1'b0 || ini_if.req !== 1'b1) begin n_fail++; $display("FAIL stall_comb: got gnt %b req %b exp 0/1", tgt_if.gnt, ini_if.req); end
    ini_if.gnt = 1;
    #1;
    n_tests++; if (tgt_if.gnt !== 1'b1) begin n_fail++; $display("FAIL stall_comb_gnt: got %b exp 1", tgt_if.gnt); end
    tick();
`endif
    idle();
  endtask

  task automatic test_single_error();
    logic [31:0] rx;
    clear_counters();
    drive_resp(32'h1234_5678, 5, -1, 1, 1, rx);
    #1;
    n_tests++; if (tgt_if.r_data !== 32'h1234_5678) begin n_fail++; $display("FAIL sgl_data: got %h exp 12345678", tgt_if.r_data); end
    n_tests++; if (single_err !== 1'b1 || multi_err !== 1'b0) begin n_fail++; $display("FAIL sgl_flag: got %b/%b exp 1/0", single_err, multi_err); end
    tick();
    ini_if.r_valid = 0;
    m_corr = 1;
    n_tests++; if (corr_cnt !== 4'd1) begin n_fail++; $display("FAIL sgl_cnt: got %0d exp 1", corr_cnt); end
    #1;
    n_tests++; if (single_err !== 1'b0) begin n_fail++; $display("FAIL sgl_pulse: got %b exp 0", single_err); end
    idle();
  endtask

  task automatic test_double_error();
    logic [31:0] rx;
    drive_resp(32'h1234_5678, 3, 9, 1, 1, rx);
    #1;
    n_tests++; if (multi_err !== 1'b1 || single_err !== 1'b0) begin n_fail++; $display("FAIL dbl_flag: got %b/%b exp 0/1", single_err, multi_err); end
    n_tests++; if (tgt_if.r_data !== rx) begin n_fail++; $display("FAIL dbl_data: got %h exp %h", tgt_if.r_data, rx); end
    tick();
    m_uncorr = 1;
    n_tests++; if (uncorr_cnt !== 4'd1 || corr_cnt !== 4'd1) begin n_fail++; $display("FAIL dbl_cnt: got %0d/%0d exp 1/1", corr_cnt, uncorr_cnt); end
    idle();
  endtask

  task automatic test_random_decode();
    logic [31:0] d, rx, exp_d; logic v, r, ev; int ne, e0, e1;
    clear_counters();
    for (int k = 0; k < 40; k++) begin
      d = $urandom; ne = $urandom_range(0, 2); e0 = -1; e1 = -1;
      if (ne >= 1) e0 = $urandom_range(0, 38);
      if (ne == 2) begin e1 = $urandom_range(0, 37); if (e1 >= e0) e1++; end
      v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0);
      drive_resp(d, e0, e1, v, r, rx);
      #1;
      ev = v && r;
      exp_d = (ne == 2) ? rx : d;
      n_tests++; if (tgt_if.r_data !== exp_d) begin n_fail++; $display("FAIL dec_data[%0d]: got %h exp %h", k, tgt_if.r_data, exp_d); end
      n_tests++; if (single_err !== 1'(ev && ne == 1) || multi_err !== 1'(ev && ne == 2))
        begin n_fail++; $display("FAIL dec_flag[%0d]: got %b/%b exp %b/%b", k, single_err, multi_err, ev && ne == 1, ev && ne == 2); end
      n_tests++; if (tgt_if.r_valid !== v || ini_if.r_ready !== r || tgt_if.r_opc !== ini_if.r_opc)
        begin n_fail++; $display("FAIL dec_pass[%0d]: got %b/%b exp %b/%b", k, tgt_if.r_valid, ini_if.r_ready, v, r); end
      tick();
      if (ev && ne == 1 && m_corr < CMAX) m_corr++;
      if (ev && ne == 2 && m_uncorr < CMAX) m_uncorr++;
      n_tests++; if (corr_cnt !== 4'(m_corr) || uncorr_cnt !== 4'(m_uncorr))
        begin n_fail++; $display("FAIL dec_cnt[%0d]: got %0d/%0d exp %0d/%0d", k, corr_cnt, uncorr_cnt, m_corr, m_uncorr); end
    end
    idle();
  endtask

  task automatic test_saturation();
    logic [31:0] rx;
    clear_counters();
    for (int k = 0; k < 20; k++) begin
      drive_resp($urandom, $urandom_range(0, 38), -1, 1, 1, rx);
      tick();
      if (k == 13) begin
        n_tests++; if (corr_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_14: got %0d exp 14", corr_cnt); end
      end
    end
    n_tests++; if (corr_cnt !== 4'd15 || uncorr_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_hold: got %0d/%0d exp 15/0", corr_cnt, uncorr_cnt); end
    drive_resp($urandom, 7, -1, 1, 1, rx);
    clear = 1;
    tick();
    clear = 0; m_corr = 0; m_uncorr = 0;
    n_tests++; if (corr_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clear: got %0d exp 0", corr_cnt); end
    idle();
  endtask

  task automatic test_reset_mid();
`ifdef HCI_ECC_ENCODER_REQ_SLICE_EN
    ini_if.gnt = 0;
    drive_req(32'hC0, 0, 32'h5555_0000, 4'hF);
    tick();
    tgt_if.req = 0;
    #2; rst = 1; #1;
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b exp 0", ini_if.req); end
    tick(); rst = 0; ini_if.gnt = 1;
    tick();
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b exp 0", ini_if.req); end
    drive_req(32'hD0, 0, 32'h6666_1111, 4'h1);
    #1;
    n_tests++; if (tgt_if.gnt !== 1'b1) begin n_fail++; $display("FAIL mid_new_gnt: got %b exp 1", tgt_if.gnt); end
    tick(); tgt_if.req = 0;
    n_tests++; if (ini_if.req !== 1'b1 || ini_if.data !== 32'h6666_1111) begin n_fail++; $display("FAIL mid_new: got %b/%h exp 1/66661111", ini_if.req, ini_if.data); end
    tick();
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL mid_dup: got %b exp 0", ini_if.req); end
`else
    ini_if.gnt = 0;
    drive_req(32'hD0, 0, 32'h6666_1111, 4'h1);
    #2; rst = 1; #1;
    n_tests++; if (ini_if.req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b exp 0", ini_if.req); end
    tick(); rst = 0; ini_if.gnt = 1;
    #1;
    n_tests++; if (ini_if.req !== 1'b1 || ini_if.data !== 32'h6666_1111 || tgt_if.gnt !== 1'b1)
      begin n_fail++; $display("FAIL mid_new: got %b/%h/%b exp 1/66661111/1", ini_if.req, ini_if.data, tgt_if.gnt); end
    tick();
`endif
    m_corr = 0; m_uncorr = 0;
    n_tests++; if (corr_cnt !== 4'(m_corr) || uncorr_cnt !== 4'(m_uncorr)) begin n_fail++; $display("FAIL mid_cnt: got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt); end
    idle();
  endtask

  initial begin
    rst = 1; clear = 0;
    idle();
    build_model();
    test_reset();
    test_write_encode();
    test_random_encode();
    test_stall();
    test_single_error();
    test_double_error();
    test_random_decode();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
